// File: rtl/mole_game_pkg.sv
// Shared types and helpers for the whack-a-mole engine.
package mole_game_pkg;

  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == '0) ? '0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Galois right-shift LFSR with synchronous seed reload.
module mole_lfsr
  import mole_game_pkg::*;
#(
  parameter int              LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = TAPS_W8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      value <= LFSR_SEED;
    else if (load)
      value <= LFSR_SEED;
    else if (enable)
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/mole_game_engine.sv
// N-mole whack-a-mole engine: LFSR mole pick, show timer, gap, score, lives.
module mole_game_engine
  import mole_game_pkg::*;
#(
  parameter int                NUM_MOLES  = 3,
  parameter int                SCORE_W    = 8,
  parameter int                TIMER_W    = 28,
  parameter int                GAP_CYCLES = 25000000,
  parameter int                MAX_MISSES = 3,
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = TAPS_W8,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h01
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 game,
  input  logic [NUM_MOLES-1:0] buttons,
  input  logic [TIMER_W-1:0]   speed,
  output logic [NUM_MOLES-1:0] moles,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           misses,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 game_over
);

  localparam int                 GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_t               state, next_state;
  logic [GAP_W-1:0]     gap_cnt, next_gap;
  logic [TIMER_W-1:0]   timer, next_timer;
  logic [NUM_MOLES-1:0] buttons_q, next_moles;
  logic [SCORE_W-1:0]   next_score;
  logic [3:0]           next_misses;
  logic                 next_hit, next_miss;
  logic                 game_q;
  logic                 game_rise;
  logic [NUM_MOLES-1:0] edges;
  logic                 wrong_press, lit_press;
  logic [LFSR_W-1:0]    lfsr;
  logic [31:0]          pick;

  assign game_rise   = game & ~game_q;
  assign edges       = buttons & ~buttons_q;
  assign wrong_press = |(edges & ~moles);
  assign lit_press   = |(edges & moles);
  assign pick        = 32'(lfsr) % 32'(NUM_MOLES);

  mole_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (game),
    .load   (game_rise),
    .value  (lfsr)
  );

  always_comb begin
    next_state  = state;
    next_moles  = moles;
    next_score  = score;
    next_misses = misses;
    next_gap    = gap_cnt;
    next_timer  = timer;
    next_hit    = 1'b0;
    next_miss   = 1'b0;
    unique case (state)
      IDLE: begin
        next_moles = '0;
        if (game_rise) begin
          next_state  = GAP;
          next_score  = '0;
          next_misses = '0;
          next_gap    = GAP_RELOAD;
        end
      end
      GAP: begin
        next_moles = '0;
        if (!game)
          next_state = IDLE;
        else if (gap_cnt == '0) begin
          next_state = SHOW;
          next_moles = NUM_MOLES'(1) << pick;
          next_timer = (speed == '0) ? '0 : speed - TIMER_W'(1);
        end else
          next_gap = gap_cnt - GAP_W'(1);
      end
      SHOW: begin
        // Wrong press outranks a hit, which outranks a same-cycle timeout.
        if (!game) begin
          next_state = IDLE;
          next_moles = '0;
        end else if (wrong_press) begin
          next_score = SCORE_W'(sat_dec(32'(score)));
          next_miss  = 1'b1;
          if (timer != '0)
            next_timer = timer - TIMER_W'(1);
        end else if (lit_press) begin
          next_score = SCORE_W'(sat_inc(32'(score), 32'(SCORE_MAX)));
          next_hit   = 1'b1;
          next_moles = '0;
          next_gap   = GAP_RELOAD;
          next_state = GAP;
        end else if (timer == '0) begin
          next_miss   = 1'b1;
          next_misses = misses + 4'd1;
          next_moles  = '0;
          if (misses + 4'd1 == 4'(MAX_MISSES))
            next_state = OVER;
          else begin
            next_gap   = GAP_RELOAD;
            next_state = GAP;
          end
        end else
          next_timer = timer - TIMER_W'(1);
      end
      OVER: begin
        next_moles = '0;
        if (!game)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      moles      <= '0;
      score      <= '0;
      misses     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      game_over  <= 1'b0;
      gap_cnt    <= '0;
      timer      <= '0;
      buttons_q  <= '0;
      game_q     <= 1'b0;
    end else begin
      state      <= next_state;
      moles      <= next_moles;
      score      <= next_score;
      misses     <= next_misses;
      hit_pulse  <= next_hit;
      miss_pulse <= next_miss;
      game_over  <= (next_state == OVER);
      gap_cnt    <= next_gap;
      timer      <= next_timer;
      buttons_q  <= buttons;
      game_q     <= game;
    end
  end

endmodule

// File: tb/tb_mole_game_engine.sv
// Directed bench for mole_game_engine with a small LFSR reference model.
module tb_mole_game_engine;

  localparam int NM  = 3;
  localparam int SW  = 4;
  localparam int TW  = 28;
  localparam int GAP = 4;
  localparam int MM  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          game;
  logic [NM-1:0] buttons;
  logic [TW-1:0] speed;
  logic [NM-1:0] moles;
  logic [SW-1:0] score;
  logic [3:0]    misses;
  logic          hit_pulse, miss_pulse, game_over;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_score  = 0;
  int exp_misses = 0;
  logic [NM-1:0] cur;

  logic [7:0] m_lfsr, m_cap;
  logic       m_gq;

  mole_game_engine #(
    .NUM_MOLES  (NM),
    .SCORE_W    (SW),
    .TIMER_W    (TW),
    .GAP_CYCLES (GAP),
    .MAX_MISSES (MM),
    .LFSR_W     (8),
    .LFSR_TAPS  (8'hB8),
    .LFSR_SEED  (8'h01)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .game       (game),
    .buttons    (buttons),
    .speed      (speed),
    .moles      (moles),
    .score      (score),
    .misses     (misses),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  // Reference LFSR; m_cap is the value seen during the cycle that just ended.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr <= 8'h01;
      m_gq   <= 1'b0;
    end else begin
      m_cap <= m_lfsr;
      if (game && !m_gq)
        m_lfsr <= 8'h01;
      else if (game)
        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
      m_gq <= game;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_show(input int dark);
    repeat (dark) begin
      @(negedge clock);
      check_eq("gap_dark", 32'(moles), 32'd0);
    end
    @(negedge clock);
    cur = NM'(3'b001 << (m_cap % 8'd3));
    check_eq("show_lit", 32'(moles), 32'(cur));
  endtask

  task automatic hit(input bit hold);
    exp_score = (exp_score == 15) ? 15 : exp_score + 1;
    buttons = cur;
    @(negedge clock);
    check_eq("hit_moles", 32'(moles), 32'd0);
    check_eq("hit_score", 32'(score), 32'(exp_score));
    check_eq("hit_pulse", 32'(hit_pulse), 32'd1);
    check_eq("hit_nomiss", 32'(miss_pulse), 32'd0);
    if (!hold) buttons = '0;
    @(negedge clock);
    check_eq("hit_pulse_1cyc", 32'(hit_pulse), 32'd0);
    check_eq("hit_dark", 32'(moles), 32'd0);
    wait_show(GAP - 2);
  endtask

  task automatic wrong(input logic [NM-1:0] extra);
    exp_score = (exp_score == 0) ? 0 : exp_score - 1;
    buttons = ((cur == 3'b001) ? 3'b010 : 3'b001) | extra;
    @(negedge clock);
    check_eq("wrong_score", 32'(score), 32'(exp_score));
    check_eq("wrong_miss", 32'(miss_pulse), 32'd1);
    check_eq("wrong_nohit", 32'(hit_pulse), 32'd0);
    check_eq("wrong_lit", 32'(moles), 32'(cur));
    buttons = '0;
    @(negedge clock);
    check_eq("wrong_pulse_1cyc", 32'(miss_pulse), 32'd0);
  endtask

  task automatic timeout(input int lit);
    repeat (lit - 1) begin
      @(negedge clock);
      check_eq("to_lit", 32'(moles), 32'(cur));
    end
    @(negedge clock);
    exp_misses++;
    check_eq("to_dark", 32'(moles), 32'd0);
    check_eq("to_miss", 32'(miss_pulse), 32'd1);
    check_eq("to_misses", 32'(misses), 32'(exp_misses));
    check_eq("to_over", 32'(game_over), (exp_misses == MM) ? 32'd1 : 32'd0);
    if (exp_misses < MM) wait_show(GAP - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; game = 1'b0; buttons = '0; speed = 28'd10;
    repeat (2) @(negedge clock);
    check_eq("rst_moles", 32'(moles), 32'd0);
    check_eq("rst_score", 32'(score), 32'd0);
    check_eq("rst_misses", 32'(misses), 32'd0);
    check_eq("rst_over", 32'(game_over), 32'd0);
    check_eq("rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    game = 1'b1;
    wait_show(GAP);
    check_eq("first_mole", 32'(moles), 32'h2);

    wrong('0);
    hit(1'b0);
    repeat (4) hit(1'b0);
    check_eq("score5", 32'(score), 32'd5);
    wrong('0);
    wrong(cur);
    hit(1'b0);

    timeout(10);
    timeout(10);
    timeout(10);
    buttons = '1;
    @(negedge clock);
    check_eq("over_score", 32'(score), 32'd4);
    check_eq("over_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
    check_eq("over_moles", 32'(moles), 32'd0);
    check_eq("over_level", 32'(game_over), 32'd1);
    buttons = '0;
    game = 1'b0;
    @(negedge clock);
    check_eq("idle_over", 32'(game_over), 32'd0);
    check_eq("idle_score", 32'(score), 32'd4);
    check_eq("idle_misses", 32'(misses), 32'd3);
    game = 1'b1;
    @(negedge clock);
    check_eq("new_score", 32'(score), 32'd0);
    check_eq("new_misses", 32'(misses), 32'd0);
    exp_score = 0;
    exp_misses = 0;
    wait_show(GAP - 1);

    repeat (16) hit(1'b0);
    check_eq("sat_score", 32'(score), 32'd15);
    hit(1'b1);
    @(negedge clock);
    check_eq("hold_nohit", 32'(hit_pulse), 32'd0);
    check_eq("hold_nomiss", 32'(miss_pulse), 32'd0);
    check_eq("hold_score", 32'(score), 32'd15);
    check_eq("hold_lit", 32'(moles), 32'(cur));
    buttons = '0;
    speed = '0;
    @(negedge clock);
    hit(1'b0);
    speed = 28'd10;
    timeout(1);

    @(negedge clock);
    reset = 1'b1;
    game = 1'b0;
    #1;
    check_eq("async_moles", 32'(moles), 32'd0);
    check_eq("async_score", 32'(score), 32'd0);
    check_eq("async_misses", 32'(misses), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    game = 1'b1;
    wait_show(GAP);
    check_eq("replay_mole", 32'(moles), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
